// File: rtl/banco_reg_pkg.sv
// Shared types and default sizing for the parameterised register file.
package banco_reg_pkg;

  typedef enum logic {
    LIMPANDO = 1'b0,
    OPERANDO = 1'b1
  } estado_t;

  localparam int LARGURA_PADRAO      = 32;
  localparam int PROFUNDIDADE_PADRAO = 32;

endpackage

// File: rtl/banco_registradores_param.sv
// Parameterised register file: 2 combinational read ports, 1 write port, zero-sweep after reset.
// Optional same-cycle write-to-read bypass enabled by defining BANCO_REG_BYPASS_EN.
module banco_registradores_param
  import banco_reg_pkg::*;
#(
  parameter int LARGURA      = LARGURA_PADRAO,
  parameter int PROFUNDIDADE = PROFUNDIDADE_PADRAO,
  parameter int END_W        = $clog2(PROFUNDIDADE)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [END_W-1:0]   regLe1,
  input  logic [END_W-1:0]   regLe2,
  input  logic [END_W-1:0]   regEsc,
  input  logic [LARGURA-1:0] dadosEsc,
  input  logic               escReg,
  output logic [LARGURA-1:0] dadosLe1,
  output logic [LARGURA-1:0] dadosLe2,
  output logic               pronto
);

  localparam logic [END_W-1:0] CONT_UM = END_W'(1);
  localparam logic [END_W-1:0] ULTIMO  = END_W'(PROFUNDIDADE - 1);

  estado_t            estado_q, estado_d;
  logic [END_W-1:0]   contador_q, contador_d;
  logic [LARGURA-1:0] banco_q [PROFUNDIDADE];
  logic               limpa_en;
  logic               esc_en;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q   <= LIMPANDO;
      contador_q <= CONT_UM;
    end else begin
      estado_q   <= estado_d;
      contador_q <= contador_d;
    end
  end

  always_comb begin
    estado_d   = estado_q;
    contador_d = contador_q;
    unique case (estado_q)
      LIMPANDO: begin
        if (contador_q == ULTIMO) estado_d = OPERANDO;
        else                      contador_d = contador_q + CONT_UM;
      end
      OPERANDO: ;
      default:  estado_d = LIMPANDO;
    endcase
  end

  assign pronto   = (estado_q == OPERANDO);
  assign limpa_en = (estado_q == LIMPANDO);
  assign esc_en   = pronto && escReg && (regEsc != '0);

  // Storage has no reset; entry 0 is never written and is masked on read.
  always_ff @(posedge clock) begin
    if (limpa_en) begin
      banco_q[contador_q] <= '0;
    end else if (esc_en) begin
      banco_q[regEsc] <= dadosEsc;
    end
  end

  always_comb begin
    dadosLe1 = '0;
    dadosLe2 = '0;
    if (pronto && (regLe1 != '0)) dadosLe1 = banco_q[regLe1];
    if (pronto && (regLe2 != '0)) dadosLe2 = banco_q[regLe2];
`ifdef BANCO_REG_BYPASS_EN
    if (esc_en && (regEsc == regLe1)) dadosLe1 = dadosEsc;
    if (esc_en && (regEsc == regLe2)) dadosLe2 = dadosEsc;
`endif
  end

endmodule

// File: tb/tb_banco_registradores_param.sv
// Directed self-checking bench for banco_registradores_param (default and 16x8 instances).
module tb_banco_registradores_param;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset;
  logic [4:0]  regLe1, regLe2, regEsc;
  logic [31:0] dadosEsc, dadosLe1, dadosLe2;
  logic        escReg, pronto;

  logic        reset_s;
  logic [2:0]  regLe1_s, regLe2_s, regEsc_s;
  logic [15:0] dadosEsc_s, dadosLe1_s, dadosLe2_s;
  logic        escReg_s, pronto_s;

  int checks   = 0;
  int failures = 0;

  banco_registradores_param dut (
    .clock(clock), .reset(reset), .regLe1(regLe1), .regLe2(regLe2), .regEsc(regEsc),
    .dadosEsc(dadosEsc), .escReg(escReg), .dadosLe1(dadosLe1), .dadosLe2(dadosLe2),
    .pronto(pronto)
  );

  banco_registradores_param #(.LARGURA(16), .PROFUNDIDADE(8)) dut_s (
    .clock(clock), .reset(reset_s), .regLe1(regLe1_s), .regLe2(regLe2_s), .regEsc(regEsc_s),
    .dadosEsc(dadosEsc_s), .escReg(escReg_s), .dadosLe1(dadosLe1_s), .dadosLe2(dadosLe2_s),
    .pronto(pronto_s)
  );

  task automatic wait_pronto(output int n);
    n = 0;
    while (!pronto && n < 60) begin
      @(posedge clock); #1;
      n++;
    end
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    @(negedge clock);
    escReg = 1'b1; regEsc = a; dadosEsc = d;
    @(negedge clock);
    escReg = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    #1;
    checks++;
    if (pronto !== 1'b0 || dadosLe1 !== 32'h0 || dadosLe2 !== 32'h0) begin
      failures++;
      $display("FAIL reset_state pronto=%b le1=%h le2=%h required pronto=0 le1=0 le2=0", pronto, dadosLe1, dadosLe2);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_pronto(n);
    checks++;
    if (n !== 31) begin
      failures++;
      $display("FAIL clear_latency cycles=%0d required=31", n);
    end
    @(negedge clock);
    for (int a = 0; a < 32; a++) begin
      regLe1 = 5'(a); regLe2 = 5'(31 - a); #1;
      checks++;
      if (dadosLe1 !== 32'h0 || dadosLe2 !== 32'h0) begin
        failures++;
        $display("FAIL cleared_reg addr=%0d le1=%h le2=%h required=0", a, dadosLe1, dadosLe2);
      end
    end
  endtask

  task automatic test_write_read;
    write_reg(5'd5, 32'hDEADBEEF);
    regLe1 = 5'd5; regLe2 = 5'd5; #1;
    checks++;
    if (dadosLe1 !== 32'hDEADBEEF || dadosLe2 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL write_read le1=%h le2=%h required=deadbeef", dadosLe1, dadosLe2);
    end
  endtask

  task automatic test_write_zero;
    write_reg(5'd0, 32'hFFFFFFFF);
    regLe1 = 5'd0; regLe2 = 5'd0; #1;
    checks++;
    if (dadosLe1 !== 32'h0 || dadosLe2 !== 32'h0) begin
      failures++;
      $display("FAIL reg0_write le1=%h le2=%h required=0", dadosLe1, dadosLe2);
    end
  endtask

  task automatic test_bypass;
    logic [31:0] exp_now;
`ifdef BANCO_REG_BYPASS_EN
    exp_now = 32'h12345678;
`else
    exp_now = 32'h0;
`endif
    @(negedge clock);
    escReg = 1'b1; regEsc = 5'd9; dadosEsc = 32'h12345678;
    regLe1 = 5'd5; regLe2 = 5'd9; #1;
    checks++;
    if (dadosLe2 !== exp_now) begin
      failures++;
      $display("FAIL bypass_same_cycle le2=%h required=%h", dadosLe2, exp_now);
    end
    checks++;
    if (dadosLe1 !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL bypass_other_port le1=%h required=deadbeef", dadosLe1);
    end
    @(negedge clock);
    escReg = 1'b0; #1;
    checks++;
    if (dadosLe2 !== 32'h12345678) begin
      failures++;
      $display("FAIL bypass_next_cycle le2=%h required=12345678", dadosLe2);
    end
  endtask

  task automatic test_back_to_back;
    write_reg(5'd1, 32'h00000001);
    write_reg(5'd31, 32'h80000000);
    @(negedge clock);
    escReg = 1'b1; regEsc = 5'd16; dadosEsc = 32'h11111111;
    @(negedge clock);
    dadosEsc = 32'h22222222;
    @(negedge clock);
    escReg = 1'b0;
    regLe1 = 5'd16; regLe2 = 5'd31; #1;
    checks++;
    if (dadosLe1 !== 32'h22222222) begin
      failures++;
      $display("FAIL back_to_back_last_wins le1=%h required=22222222", dadosLe1);
    end
    checks++;
    if (dadosLe2 !== 32'h80000000) begin
      failures++;
      $display("FAIL top_addr le2=%h required=80000000", dadosLe2);
    end
    regLe1 = 5'd1; regLe2 = 5'd1; #1;
    checks++;
    if (dadosLe1 !== 32'h00000001 || dadosLe2 !== 32'h00000001) begin
      failures++;
      $display("FAIL same_addr_ports le1=%h le2=%h required=00000001", dadosLe1, dadosLe2);
    end
  endtask

  task automatic test_reset_mid_sweep;
    int n;
    write_reg(5'd7, 32'hA5A5A5A5);
    regLe1 = 5'd7; regLe2 = 5'd5; #1;
    checks++;
    if (dadosLe1 !== 32'hA5A5A5A5) begin
      failures++;
      $display("FAIL reg7_write le1=%h required=a5a5a5a5", dadosLe1);
    end
    @(negedge clock);
    reset = 1'b1; #1;
    checks++;
    if (pronto !== 1'b0 || dadosLe1 !== 32'h0 || dadosLe2 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_operating pronto=%b le1=%h le2=%h required 0/0/0", pronto, dadosLe1, dadosLe2);
    end
    @(negedge clock);
    reset = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1; #1;
    checks++;
    if (pronto !== 1'b0 || dadosLe1 !== 32'h0) begin
      failures++;
      $display("FAIL async_reset_sweep pronto=%b le1=%h required 0/0", pronto, dadosLe1);
    end
    @(negedge clock);
    reset = 1'b0;
    wait_pronto(n);
    checks++;
    if (n !== 31) begin
      failures++;
      $display("FAIL restart_latency cycles=%0d required=31", n);
    end
    @(negedge clock); #1;
    checks++;
    if (dadosLe1 !== 32'h0 || dadosLe2 !== 32'h0) begin
      failures++;
      $display("FAIL cleared_after_restart le1=%h le2=%h required=0", dadosLe1, dadosLe2);
    end
  endtask

  task automatic test_small;
    int n;
    @(negedge clock);
    reset_s = 1'b0;
    escReg_s = 1'b1; regEsc_s = 3'd7; dadosEsc_s = 16'hBEEF;
    regLe1_s = 3'd7; regLe2_s = 3'd7;
    #1;
    checks++;
    if (dadosLe1_s !== 16'h0 || pronto_s !== 1'b0) begin
      failures++;
      $display("FAIL small_sweep_read le1=%h pronto=%b required 0/0", dadosLe1_s, pronto_s);
    end
    n = 0;
    while (!pronto_s && n < 30) begin
      @(posedge clock); #1;
      n++;
    end
    escReg_s = 1'b0;
    checks++;
    if (n !== 7) begin
      failures++;
      $display("FAIL small_latency cycles=%0d required=7", n);
    end
    @(negedge clock); #1;
    checks++;
    if (dadosLe1_s !== 16'h0 || dadosLe2_s !== 16'h0) begin
      failures++;
      $display("FAIL small_write_ignored le1=%h le2=%h required=0", dadosLe1_s, dadosLe2_s);
    end
    escReg_s = 1'b1; regEsc_s = 3'd3; dadosEsc_s = 16'h1234;
    @(negedge clock);
    escReg_s = 1'b0; regLe1_s = 3'd3; #1;
    checks++;
    if (dadosLe1_s !== 16'h1234) begin
      failures++;
      $display("FAIL small_write_read le1=%h required=1234", dadosLe1_s);
    end
  endtask

  initial begin
    reset = 1'b1; escReg = 1'b0; regEsc = '0; dadosEsc = '0; regLe1 = '0; regLe2 = '0;
    reset_s = 1'b1; escReg_s = 1'b0; regEsc_s = '0; dadosEsc_s = '0; regLe1_s = '0; regLe2_s = '0;
    test_reset();
    test_write_read();
    test_write_zero();
    test_bypass();
    test_back_to_back();
    test_reset_mid_sweep();
    test_small();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
